// File: rtl/fighter_pkg.sv
// Shared attack-state encoding, key bindings and body geometry
// for the fighter controller and its attack sequencer.
package fighter_pkg;

    typedef enum logic [2:0] {
        ACT_IDLE    = 3'd0,
        ACT_PUNCH   = 3'd1,
        ACT_KICK    = 3'd2,
        ACT_BLOCK   = 3'd3,
        ACT_RECOVER = 3'd4
    } act_e;

    typedef logic signed [10:0] s11_t;

    localparam logic [7:0] KEY_L_DEF = 8'h50;
    localparam logic [7:0] KEY_R_DEF = 8'h4F;
    localparam logic [7:0] KEY_J_DEF = 8'h52;
    localparam logic [7:0] KEY_P_DEF = 8'h59;
    localparam logic [7:0] KEY_K_DEF = 8'h62;
    localparam logic [7:0] KEY_B_DEF = 8'h51;

    localparam int X_START_DEF        = 480;
    localparam int Y_START_DEF        = 360;
    localparam int X_MIN_DEF          = 94;
    localparam int X_MAX_DEF          = 638;
    localparam int Y_GROUND_DEF       = 420;
    localparam int HALF_W_DEF         = 45;
    localparam int HEAD_DEF           = 90;
    localparam int FEET_DEF           = 60;
    localparam int STEP_DEF           = 3;
    localparam int JUMP_V_DEF         = 30;
    localparam int GRAV_DEF           = 3;
    localparam int PUNCH_FRAMES_DEF   = 8;
    localparam int KICK_FRAMES_DEF    = 12;
    localparam int RECOVER_FRAMES_DEF = 6;

    function automatic logic key_held(
        input logic [7:0] kc_a,
        input logic [7:0] kc_b,
        input logic [7:0] key
    );
        return (kc_a == key) || (kc_b == key);
    endfunction

    function automatic s11_t abs11(input s11_t v);
        return v[10] ? -v : v;
    endfunction

endpackage

// File: rtl/fighter_attack_fsm.sv
// Attack sequencer: edge-triggered punch/kick, level-held block,
// fixed-length recovery, and a one-frame strike pulse.
module fighter_attack_fsm
    import fighter_pkg::*;
#(
    parameter int PUNCH_FRAMES   = PUNCH_FRAMES_DEF,
    parameter int KICK_FRAMES    = KICK_FRAMES_DEF,
    parameter int RECOVER_FRAMES = RECOVER_FRAMES_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       i_freeze,
    input  logic       i_punch,
    input  logic       i_kick,
    input  logic       i_block,
    input  logic       i_in_range,
    output logic [2:0] o_state,
    output logic       o_hit
);

    localparam int CW = 8;

    act_e          r_state;
    act_e          w_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic          r_prev_p;
    logic          r_prev_k;
    logic          r_hit;
    logic          w_hit;
    logic          w_p_edge;
    logic          w_k_edge;

    assign w_p_edge = i_punch && !r_prev_p;
    assign w_k_edge = i_kick && !r_prev_k;
    assign o_state  = r_state;
    assign o_hit    = r_hit;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ACT_IDLE;
            r_cnt    <= '0;
            r_prev_p <= 1'b0;
            r_prev_k <= 1'b0;
            r_hit    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_prev_p <= i_punch;
            r_prev_k <= i_kick;
            r_hit    <= w_hit;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_hit   = 1'b0;

        unique case (r_state)
            ACT_IDLE: begin
                w_cnt = '0;
                if (i_block)       w_state = ACT_BLOCK;
                else if (w_k_edge) w_state = ACT_KICK;
                else if (w_p_edge) w_state = ACT_PUNCH;
            end
            ACT_PUNCH: begin
                if (r_cnt == CW'(PUNCH_FRAMES - 1)) begin
                    w_state = ACT_RECOVER;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ACT_KICK: begin
                if (r_cnt == CW'(KICK_FRAMES - 1)) begin
                    w_state = ACT_RECOVER;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ACT_RECOVER: begin
                if (r_cnt == CW'(RECOVER_FRAMES - 1)) begin
                    w_state = ACT_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ACT_BLOCK: begin
                w_cnt = '0;
                if (!i_block) w_state = ACT_IDLE;
            end
            default: begin
                w_state = ACT_IDLE;
                w_cnt   = '0;
            end
        endcase

        // Frozen fighters drop any attack; edge regs still track keys.
        if (i_freeze) begin
            w_state = ACT_IDLE;
            w_cnt   = '0;
        end

        w_hit = i_in_range && !i_freeze &&
            ((w_state == ACT_PUNCH &&
              w_cnt == CW'(PUNCH_FRAMES / 2)) ||
             (w_state == ACT_KICK &&
              w_cnt == CW'(KICK_FRAMES / 2)));
    end

endmodule

// File: rtl/fighter_ctrl.sv
// Fighter kinematics: walking, jumping, walls, floor and body
// collision; the attack sequencer lives in fighter_attack_fsm.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int         X_START        = X_START_DEF,
    parameter int         Y_START        = Y_START_DEF,
    parameter int         X_MIN          = X_MIN_DEF,
    parameter int         X_MAX          = X_MAX_DEF,
    parameter int         Y_GROUND       = Y_GROUND_DEF,
    parameter int         HALF_W         = HALF_W_DEF,
    parameter int         HEAD           = HEAD_DEF,
    parameter int         FEET           = FEET_DEF,
    parameter int         STEP           = STEP_DEF,
    parameter int         JUMP_V         = JUMP_V_DEF,
    parameter int         GRAV           = GRAV_DEF,
    parameter int         PUNCH_FRAMES   = PUNCH_FRAMES_DEF,
    parameter int         KICK_FRAMES    = KICK_FRAMES_DEF,
    parameter int         RECOVER_FRAMES = RECOVER_FRAMES_DEF,
    parameter logic [7:0] KEY_L          = KEY_L_DEF,
    parameter logic [7:0] KEY_R          = KEY_R_DEF,
    parameter logic [7:0] KEY_J          = KEY_J_DEF,
    parameter logic [7:0] KEY_P          = KEY_P_DEF,
    parameter logic [7:0] KEY_K          = KEY_K_DEF,
    parameter logic [7:0] KEY_B          = KEY_B_DEF
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    input  logic       freeze,
    input  logic [9:0] opp_x,
    input  logic [9:0] opp_y,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [9:0] vel_y,
    output logic       airborne,
    output logic [2:0] act_state,
    output logic       punch_o,
    output logic       kick_o,
    output logic       block_o,
    output logic       hit_pulse
);

    localparam s11_t L_X_LO   = s11_t'(X_MIN + HALF_W);
    localparam s11_t L_X_HI   = s11_t'(X_MAX - HALF_W);
    localparam s11_t L_BODY   = s11_t'(2 * HALF_W);
    localparam s11_t L_REACH  = s11_t'(2 * HALF_W + 4 * STEP);
    localparam s11_t L_VSPAN  = s11_t'(HEAD + FEET);
    localparam s11_t L_FEET   = s11_t'(FEET);
    localparam s11_t L_GROUND = s11_t'(Y_GROUND);
    localparam s11_t L_REST   = s11_t'(Y_GROUND - FEET);
    localparam s11_t L_STEP   = s11_t'(STEP);
    localparam s11_t L_JUMP   = s11_t'(JUMP_V);
    localparam s11_t L_GRAV   = s11_t'(GRAV);

    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [9:0] r_vel_y;
    logic       r_air;

    logic w_l, w_r, w_j, w_p, w_k, w_b;
    logic w_idle;
    logic w_jump;
    logic w_y_near;
    logic w_in_range;
    s11_t w_x, w_ox, w_y, w_oy, w_vy;
    s11_t w_dx;
    s11_t w_x_try;
    s11_t w_x_col;
    s11_t w_x_next;
    s11_t w_y_try;
    s11_t w_y_next;
    s11_t w_vy_next;
    logic w_air_next;

    assign w_l = key_held(keycode, keycode2, KEY_L);
    assign w_r = key_held(keycode, keycode2, KEY_R);
    assign w_j = key_held(keycode, keycode2, KEY_J);
    assign w_p = key_held(keycode, keycode2, KEY_P);
    assign w_k = key_held(keycode, keycode2, KEY_K);
    assign w_b = key_held(keycode, keycode2, KEY_B);

    // X spans 0..639, so it is carried as an unsigned screen coordinate.
    assign w_x  = $signed({1'b0, r_pos_x});
    assign w_ox = $signed({1'b0, opp_x});
    assign w_y  = $signed({r_pos_y[9], r_pos_y});
    assign w_oy = $signed({opp_y[9], opp_y});
    assign w_vy = $signed({r_vel_y[9], r_vel_y});

    assign w_idle     = (act_state == ACT_IDLE);
    assign w_y_near   = abs11(w_y - w_oy) < L_VSPAN;
    assign w_in_range = abs11(w_x - w_ox) <= L_REACH;

    always_comb begin
        w_dx = '0;
        unique case (1'b1)
            (w_r && !w_l): w_dx = L_STEP;
            (w_l && !w_r): w_dx = -L_STEP;
            default:       w_dx = '0;
        endcase
        if (freeze || (!r_air && !w_idle)) w_dx = '0;
    end

    always_comb begin
        w_x_try = w_x + w_dx;
        w_x_col = w_x_try;
        // Only a step toward the opponent can be stopped at body contact.
        if (w_y_near && abs11(w_x_try - w_ox) < L_BODY) begin
            if (!w_dx[10] && w_dx != '0 && w_x < w_ox)
                w_x_col = w_ox - L_BODY;
            else if (w_dx[10] && w_x > w_ox)
                w_x_col = w_ox + L_BODY;
        end
        w_x_next = w_x_col;
        if (w_x_col < L_X_LO) w_x_next = L_X_LO;
        if (w_x_col > L_X_HI) w_x_next = L_X_HI;
        if (freeze)           w_x_next = w_x;
    end

    assign w_jump = !r_air && w_idle && w_j && !freeze;

    always_comb begin
        w_y_try    = w_y + w_vy;
        w_y_next   = w_y;
        w_vy_next  = '0;
        w_air_next = r_air;
        if (freeze) begin
            w_vy_next = '0;
        end else if (r_air) begin
            if (w_y_try + L_FEET >= L_GROUND) begin
                w_y_next   = L_REST;
                w_air_next = 1'b0;
            end else begin
                w_y_next  = w_y_try;
                w_vy_next = w_vy + L_GRAV;
            end
        end else if (w_jump) begin
            w_vy_next  = -L_JUMP;
            w_air_next = 1'b1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_pos_x <= 10'(X_START);
            r_pos_y <= 10'(Y_START);
            r_vel_y <= '0;
            r_air   <= 1'b1;
        end else begin
            r_pos_x <= w_x_next[9:0];
            r_pos_y <= w_y_next[9:0];
            r_vel_y <= w_vy_next[9:0];
            r_air   <= w_air_next;
        end
    end

    fighter_attack_fsm #(
        .PUNCH_FRAMES   (PUNCH_FRAMES),
        .KICK_FRAMES    (KICK_FRAMES),
        .RECOVER_FRAMES (RECOVER_FRAMES)
    ) u_attack (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .i_freeze   (freeze),
        .i_punch    (w_p),
        .i_kick     (w_k),
        .i_block    (w_b),
        .i_in_range (w_in_range),
        .o_state    (act_state),
        .o_hit      (hit_pulse)
    );

    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign vel_y    = r_vel_y;
    assign airborne = r_air;
    assign punch_o  = (act_state == ACT_PUNCH);
    assign kick_o   = (act_state == ACT_KICK);
    assign block_o  = (act_state == ACT_BLOCK);

endmodule

// File: tb/tb_fighter_ctrl.sv
// Scoreboard bench for fighter_ctrl: stimulus queues expected
// per-frame values, a negedge monitor pops and compares them.
module tb_fighter_ctrl;

    localparam logic [7:0] KL = 8'h50;
    localparam logic [7:0] KR = 8'h4F;
    localparam logic [7:0] KJ = 8'h52;
    localparam logic [7:0] KP = 8'h59;
    localparam logic [7:0] KK = 8'h62;
    localparam logic [7:0] KB = 8'h51;

    localparam int SX = 0;
    localparam int SY = 1;
    localparam int SV = 2;
    localparam int SA = 3;
    localparam int SS = 4;
    localparam int SH = 5;
    localparam int SP = 6;
    localparam int SK = 7;
    localparam int SB = 8;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [7:0] keycode2;
    logic       freeze;
    logic [9:0] opp_x;
    logic [9:0] opp_y;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] vel_y;
    logic       airborne;
    logic [2:0] act_state;
    logic       punch_o;
    logic       kick_o;
    logic       block_o;
    logic       hit_pulse;

    fighter_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .keycode2  (keycode2),
        .freeze    (freeze),
        .opp_x     (opp_x),
        .opp_y     (opp_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .vel_y     (vel_y),
        .airborne  (airborne),
        .act_state (act_state),
        .punch_o   (punch_o),
        .kick_o    (kick_o),
        .block_o   (block_o),
        .hit_pulse (hit_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int    frame;
        string name;
        int    sig;
        int    exp;
    } sb_t;

    sb_t sb[$];
    int  f_cnt  = 0;
    int  checks = 0;
    int  errs   = 0;

    always @(posedge frame_clk) f_cnt <= f_cnt + 1;

    function automatic int sample(input int s);
        case (s)
            SX:      return int'(pos_x);
            SY:      return int'($signed(pos_y));
            SV:      return int'($signed(vel_y));
            SA:      return int'(airborne);
            SS:      return int'(act_state);
            SH:      return int'(hit_pulse);
            SP:      return int'(punch_o);
            SK:      return int'(kick_o);
            SB:      return int'(block_o);
            default: return -9999;
        endcase
    endfunction

    task automatic push(input int dly, input string nm,
                        input int sig, input int val);
        sb_t e;
        e.frame = f_cnt + dly;
        e.name  = nm;
        e.sig   = sig;
        e.exp   = val;
        sb.push_back(e);
    endtask

    task automatic frame();
        @(posedge frame_clk);
        #2;
    endtask

    sb_t mon_e;
    int  mon_got;

    always @(negedge frame_clk) begin
        while (sb.size() > 0 && sb[0].frame <= f_cnt) begin
            mon_e   = sb.pop_front();
            mon_got = sample(mon_e.sig);
            checks  = checks + 1;
            if (mon_e.frame != f_cnt) begin
                errs = errs + 1;
                $display("FAIL %s stale: due frame %0d, now %0d",
                         mon_e.name, mon_e.frame, f_cnt);
            end else if (mon_got != mon_e.exp) begin
                errs = errs + 1;
                $display("FAIL %s frame=%0d got=%0d want=%0d",
                         mon_e.name, f_cnt, mon_got, mon_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset    = 1'b1;
        keycode  = 8'h00;
        keycode2 = 8'h00;
        freeze   = 1'b0;
        opp_x    = 10'd100;
        opp_y    = 10'(-300);

        // Reset state
        frame();
        frame();
        push(0, "rst_x", SX, 480);
        push(0, "rst_y", SY, 360);
        push(0, "rst_v", SV, 0);
        push(0, "rst_air", SA, 1);
        push(0, "rst_act", SS, 0);
        push(0, "rst_hit", SH, 0);
        push(0, "rst_punch", SP, 0);
        push(0, "rst_kick", SK, 0);
        push(0, "rst_block", SB, 0);
        Reset = 1'b0;
        frame();
        push(0, "land_air", SA, 0);
        push(0, "land_y", SY, 360);

        // Walk right into the wall: 480 + 3k capped at 593
        keycode = KR;
        for (int k = 1; k <= 200; k++)
            push(k, "walk_x", SX, (480 + 3 * k > 593) ? 593 : 480 + 3 * k);
        repeat (200) frame();
        keycode = 8'h00;

        // Jump arc from the floor
        keycode = KJ;
        push(1, "jmp0_y", SY, 360);
        push(1, "jmp0_v", SV, -30);
        push(1, "jmp0_air", SA, 1);
        frame();
        keycode = 8'h00;
        for (int m = 1; m <= 20; m++) begin
            push(m, "jmp_y", SY, 360 - 30 * m + (3 * m * (m - 1)) / 2);
            push(m, "jmp_v", SV, -30 + 3 * m);
            push(m, "jmp_air", SA, 1);
        end
        push(21, "jmp_land_y", SY, 360);
        push(21, "jmp_land_v", SV, 0);
        push(21, "jmp_land_air", SA, 0);
        push(21, "jmp_land_x", SX, 593);
        repeat (21) frame();

        // Asynchronous reset while airborne
        keycode = KJ;
        frame();
        keycode = 8'h00;
        push(1, "rj_y", SY, 330);
        frame();
        push(1, "rj_y2", SY, 303);
        frame();
        frame();
        Reset = 1'b1;
        opp_x = 10'd560;
        opp_y = 10'd360;
        push(0, "ar_x", SX, 480);
        push(0, "ar_y", SY, 360);
        push(0, "ar_v", SV, 0);
        push(0, "ar_air", SA, 1);
        frame();
        Reset = 1'b0;
        push(1, "ar_land_air", SA, 0);
        push(1, "ar_land_x", SX, 480);
        frame();

        // Body collision: approach stops at 470, retreat is free
        keycode = KR;
        for (int k = 1; k <= 10; k++)
            push(k, "col_x", SX, 470);
        repeat (10) frame();
        keycode = KL;
        push(1, "away_x1", SX, 467);
        push(2, "away_x2", SX, 464);
        repeat (2) frame();
        keycode = 8'h00;

        // Kick in reach: pulse on middle frame only
        keycode = KK;
        push(1, "kick_on", SK, 1);
        push(1, "kick_act", SS, 2);
        push(6, "kick_hit6", SH, 0);
        push(7, "kick_hit7", SH, 1);
        push(8, "kick_hit8", SH, 0);
        push(12, "kick_last", SS, 2);
        push(13, "kick_rec", SS, 4);
        push(18, "kick_rec_end", SS, 4);
        push(19, "kick_idle", SS, 0);
        repeat (19) frame();
        keycode = 8'h00;

        // Punch out of reach, walking key on keycode2,
        // re-press during recovery is dropped
        opp_x    = 10'd100;
        opp_y    = 10'(-300);
        keycode  = KP;
        keycode2 = KR;
        for (int k = 1; k <= 20; k++) begin
            push(k, "pun_act", SS, (k <= 8) ? 1 : (k <= 14) ? 4 : 0);
            push(k, "pun_x", SX, (k <= 15) ? 467 : 467 + 3 * (k - 15));
            if (k == 5) push(k, "pun_nohit", SH, 0);
        end
        for (int k = 1; k <= 20; k++) begin
            frame();
            if (k == 4)  keycode = 8'h00;
            if (k == 10) keycode = KP;
        end
        keycode  = 8'h00;
        keycode2 = 8'h00;

        // Block beats a simultaneous kick edge
        keycode  = KK;
        keycode2 = KB;
        push(1, "blk_act", SS, 3);
        push(1, "blk_on", SB, 1);
        push(3, "blk_hold", SS, 3);
        repeat (3) frame();
        keycode2 = 8'h00;
        push(1, "blk_rel", SS, 0);
        push(1, "blk_off", SB, 0);
        push(2, "blk_nokick", SK, 0);
        push(3, "blk_idle", SS, 0);
        repeat (3) frame();
        keycode = 8'h00;

        // Freeze mid-air with punch held
        keycode = KJ;
        push(1, "fz_jv", SV, -30);
        frame();
        keycode = 8'h00;
        push(1, "fz_y0", SY, 330);
        frame();
        keycode = KP;
        freeze  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(k, "fz_y", SY, 330);
            push(k, "fz_v", SV, 0);
            push(k, "fz_air", SA, 1);
            push(k, "fz_act", SS, 0);
            push(k, "fz_x", SX, 482);
        end
        repeat (4) frame();
        freeze = 1'b0;
        push(1, "uf_act", SS, 0);
        push(1, "uf_y", SY, 330);
        push(1, "uf_v", SV, 3);
        push(2, "uf_act2", SS, 0);
        push(2, "uf_y2", SY, 333);
        push(3, "uf_punch", SP, 0);
        push(3, "uf_y3", SY, 339);
        repeat (3) frame();
        keycode = 8'h00;
        push(1, "uf_y4", SY, 348);
        push(2, "uf_land_y", SY, 360);
        push(2, "uf_land_air", SA, 0);
        repeat (2) frame();

        // Jump and punch started together
        keycode  = KJ;
        keycode2 = KP;
        push(1, "jp_air", SA, 1);
        push(1, "jp_v", SV, -30);
        push(1, "jp_act", SS, 1);
        push(1, "jp_punch", SP, 1);
        frame();
        keycode  = 8'h00;
        keycode2 = 8'h00;
        push(1, "jp_y", SY, 330);
        push(1, "jp_act2", SS, 1);
        repeat (3) frame();

        if (sb.size() != 0) begin
            checks = checks + 1;
            errs   = errs + 1;
            $display("FAIL drain: %0d expectations unchecked, want 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fighter_ctrl.md
FIGHTER_CTRL -- requirements
Module: fighter_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- X_START, 480: reset centre X.
- Y_START, 360: reset centre Y.
- X_MIN, 94: left arena wall.
- X_MAX, 638: right arena wall.
- Y_GROUND, 420: floor line.
- HALF_W, 45: half body width.
- HEAD, 90: centre-to-top distance.
- FEET, 60: centre-to-bottom distance.
- STEP, 3: walk speed in px/frame.
- JUMP_V, 30: launch speed.
- GRAV, 3: gravity in px/frame².
- PUNCH_FRAMES, 8: punch duration.
- KICK_FRAMES, 12: kick duration.
- RECOVER_FRAMES, 6: post-attack lockout.
- KEY_L, KEY_R, KEY_J, KEY_P, KEY_K, KEY_B, 8'h50/4F/52/59/62/51: key bindings.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- frame_clk, in, 1: frame clock, one tick per video frame.
- Reset, in, 1: asynchronous, active-high.
- keycode, keycode2, in, 8 each: currently held keys.
- freeze, in, 1: death or start screen active.
- opp_x, opp_y, in, 10 signed: opponent centre.
- pos_x, pos_y, out, 10 signed: own centre.
- vel_y, out, 10 signed: vertical velocity.
- airborne, out, 1: fighter is off the ground.
- act_state, out, 3: attack FSM state.
- punch_o, kick_o, block_o, out, 1: action is active.
- hit_pulse, out, 1: one-frame strike event.

Function
REQ-003 All state SHALL update only on posedge frame_clk; every output SHALL be a register or a decode of registers.
REQ-004 A key SHALL count as held when it appears on keycode or on keycode2.
REQ-005 Jump: when !airborne, act_state==IDLE, KEY_J is held and !freeze, the block SHALL set vel_y=-JUMP_V and airborne=1 on the next frame.
REQ-006 While airborne, each frame SHALL apply vel_y+=GRAV and pos_y+=vel_y (old vel_y); if pos_y+FEET would reach Y_GROUND or beyond, it SHALL clamp pos_y=Y_GROUND-FEET, vel_y=0, airborne=0 in that same frame.
REQ-007 Walk: with KEY_R only held, dx=+STEP; with KEY_L only held, dx=-STEP; with both or neither held, dx=0.
REQ-008 On the ground, dx SHALL be 0 unless act_state==IDLE; in the air, dx SHALL be kept in every state.
REQ-009 The X result SHALL clamp to [X_MIN+HALF_W, X_MAX-HALF_W] exactly, with no overshoot.
REQ-010 Body collision: if |pos_y-opp_y| < HEAD+FEET and the move would make |new_x-opp_x| < 2*HALF_W, pos_x SHALL stop at opp_x∓2*HALF_W on the approach side; a move away from the opponent SHALL never be blocked.
REQ-011 Attack FSM states SHALL be IDLE, PUNCH, KICK, BLOCK, RECOVER.
REQ-012 From IDLE the priority SHALL be BLOCK (KEY_B held) > KICK (KEY_K rising edge) > PUNCH (KEY_P rising edge); a rising edge is held now and not held on the previous frame.
REQ-013 PUNCH and KICK SHALL last exactly PUNCH_FRAMES and KICK_FRAMES frames, then go to RECOVER for RECOVER_FRAMES frames, then return to IDLE.
REQ-014 BLOCK SHALL persist while KEY_B is held and return to IDLE on the first frame it is released; it SHALL have no recovery.
REQ-015 Attack key edges that arrive outside IDLE SHALL be discarded, not queued.
REQ-016 hit_pulse SHALL assert for exactly one frame, on the middle frame of PUNCH or KICK (counter == duration/2), when |pos_x-opp_x| ≤ 2*HALF_W+STEP*4.
REQ-017 punch_o, kick_o and block_o SHALL be one-hot decodes of act_state.
REQ-018 When freeze=1: dx=0, vel_y=0, pos held (an airborne fighter freezes mid-air), FSM forced to IDLE, counters cleared, edge registers loaded with current keys so no spurious edge occurs at unfreeze.
REQ-019 Simultaneous jump edge and attack edge in IDLE on the ground SHALL start both.
REQ-020 All arithmetic SHALL be signed 10-bit; intermediates SHALL be 11-bit to detect wall and floor crossing before clamping.

Reset
REQ-021 Reset SHALL force pos_x=X_START, pos_y=Y_START, vel_y=0, airborne=1, act_state=IDLE, counters=0, edge registers=0, hit_pulse=0, all action outputs 0.
REQ-022 Reset asserted mid-jump or mid-attack SHALL take effect immediately, without waiting for frame_clk.

Structure
REQ-023 The act_state enum, key-code defaults and body-geometry defaults SHALL live in shared package fighter_pkg.
REQ-024 The attack FSM with its counter and edge detection SHALL be sub-module fighter_attack_fsm; kinematics SHALL remain in fighter_ctrl.

Verification
REQ-025 Reset, then hold 8'h4F for 200 frames -> pos_x rises by 3/frame and stops at exactly 593 with no overshoot.
REQ-026 Grounded, press 8'h52 -> vel_y sequence -30, -27, ..., then landing with pos_y=360, airborne=0 and no sub-floor frame.
REQ-027 Press 8'h59 once, hold 20 frames -> PUNCH for 8 frames, RECOVER for 6 frames, IDLE; a second press during RECOVER is ignored.
REQ-028 opp_x=560, opp_y=360, hold 8'h4F from 480 -> pos_x stops at 470 and never lies between 471 and 649.
REQ-029 Press 8'h62 and 8'h51 in the same frame -> BLOCK; release 8'h51 -> IDLE; no kick is issued.
REQ-030 Assert freeze mid-air while 8'h59 is held, then deassert -> pos frozen, FSM IDLE, and no punch starts after release of freeze.
